// File: rtl/booth2_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states, digit codes
// and the digit-count helper.
package booth2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit code is {negate, magnitude[1:0]}; magnitude 01 = x, 10 = 2x.
  localparam logic [2:0] DIG_ZERO = 3'b000;
  localparam logic [2:0] DIG_P1   = 3'b001;
  localparam logic [2:0] DIG_P2   = 3'b010;
  localparam logic [2:0] DIG_M1   = 3'b101;
  localparam logic [2:0] DIG_M2   = 3'b110;

  // W+2 bit extended operands need one extra digit beyond W/2.
  function automatic int num_digits(input int w);
    return w / 2 + 1;
  endfunction

  function automatic logic [2:0] booth_recode(input logic [2:0] trip);
    logic [2:0] d;
    case (trip)
      3'b001, 3'b010: d = DIG_P1;
      3'b011:         d = DIG_P2;
      3'b100:         d = DIG_M2;
      3'b101, 3'b110: d = DIG_M1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth2_pp_gen.sv
// Booth digit recoder and partial-product selector. Negative digits come out
// bit-inverted; the +1 is supplied to the accumulator adder through neg.
module booth2_pp_gen
  import booth2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W+1:0] x_ext,
  input  logic [2:0]   triplet,
  output logic [W+2:0] pp,
  output logic         neg
);

  logic [2:0]   digit;
  logic [W+2:0] mag;

  always_comb begin
    digit = booth_recode(triplet);
    case (digit[1:0])
      2'b01:   mag = {x_ext[W+1], x_ext};
      2'b10:   mag = {x_ext, 1'b0};
      default: mag = '0;
    endcase
    neg = digit[2];
    pp  = neg ? ~mag : mag;
  end

endmodule

// File: rtl/booth2_mult_param.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides;
// one partial product per CALC cycle followed by a result write-back cycle.
module booth2_mult_param
  import booth2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     multiplier,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   result,
  output logic             busy
);

  localparam int N  = num_digits(W);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  state_t           state_reg, state_next;
  logic [W+1:0]     x_reg;
  logic [W+1:0]     hi_reg;
  logic [W+1:0]     lo_reg;
  logic             prev_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2*W-1:0]   result_reg;
  logic             accept;
  logic [W+2:0]     pp;
  logic             pp_neg;
  logic [W+3:0]     sum;

  booth2_pp_gen #(.W(W)) u_pp_gen (
    .x_ext   (x_reg),
    .triplet ({lo_reg[1:0], prev_reg}),
    .pp      (pp),
    .neg     (pp_neg)
  );

  // Two guard bits keep hi + pp from overflowing before the 2-bit shift.
  assign sum = {{2{hi_reg[W+1]}}, hi_reg} + {pp[W+2], pp} + {{(W+3){1'b0}}, pp_neg};

  always_comb begin
    in_ready   = (state_reg == IDLE) || (state_reg == DONE && out_ready);
    accept     = in_valid && in_ready;
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (cnt_reg == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = accept ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      prev_reg   <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        x_reg    <= is_signed ? {{2{x[W-1]}}, x} : {2'b00, x};
        lo_reg   <= is_signed ? {{2{multiplier[W-1]}}, multiplier} : {2'b00, multiplier};
        hi_reg   <= '0;
        prev_reg <= 1'b0;
        cnt_reg  <= '0;
      end else if (state_reg == CALC) begin
        if (cnt_reg == LAST) begin
          // After N shifts the full 2W+4 bit product sits in {hi, lo}.
          result_reg <= {hi_reg[W-3:0], lo_reg};
        end else begin
          hi_reg   <= sum[W+3:2];
          lo_reg   <= {sum[1:0], lo_reg[W+1:2]};
          prev_reg <= lo_reg[1];
          cnt_reg  <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == CALC);
  assign result    = result_reg;

endmodule

// File: tb/tb_booth2_mult_param.sv
// Directed and random checks of booth2_mult_param at W=8 and W=16 against an
// arithmetic reference product.
module tb_booth2_mult_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v8, rdy8, s8, ov8, or8, busy8;
  logic [7:0]  x8, m8;
  logic [15:0] res8;
  logic        v16, rdy16, s16, ov16, or16, busy16;
  logic [15:0] x16, m16;
  logic [31:0] res16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth2_mult_param #(.W(8)) dut8 (
    .CLK(clk), .RST(rst_n), .in_valid(v8), .in_ready(rdy8), .x(x8),
    .multiplier(m8), .is_signed(s8), .out_valid(ov8), .out_ready(or8),
    .result(res8), .busy(busy8)
  );

  booth2_mult_param #(.W(16)) dut16 (
    .CLK(clk), .RST(rst_n), .in_valid(v16), .in_ready(rdy16), .x(x16),
    .multiplier(m16), .is_signed(s16), .out_valid(ov16), .out_ready(or16),
    .result(res16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    longint sa, sb, p;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'({32'd0, a} & mask);
    sb = longint'({32'd0, b} & mask);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : ov16;
  endfunction
  function automatic logic get_rdy(input int w);
    return (w == 8) ? rdy8 : rdy16;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic [63:0] get_res(input int w);
    return (w == 8) ? {48'd0, res8} : {32'd0, res16};
  endfunction

  task automatic set_in(input int w, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
    if (w == 8) begin
      v8 = v; x8 = a[7:0]; m8 = b[7:0]; s8 = s;
    end else begin
      v16 = v; x16 = a[15:0]; m16 = b[15:0]; s16 = s;
    end
  endtask

  task automatic set_or(input int w, input logic r);
    if (w == 8) or8 = r; else or16 = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation for one edge; the DUT is expected to be ready.
  task automatic start_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
    set_in(w, 1'b1, a, b, s);
    tick();
    set_in(w, 1'b0, a, b, s);
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_done(input int w, output logic [63:0] res, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!get_ov(w) && lat < 64);
    check("out_valid_seen", {63'd0, get_ov(w)}, 64'd1);
    res = get_res(w);
  endtask

  task automatic ack(input int w);
    set_or(w, 1'b1);
    tick();
    set_or(w, 1'b0);
  endtask

  logic [63:0] res;
  int          lat;
  logic [31:0] ra, rb;
  bit          stray;

  initial begin
    rst_n = 1'b0;
    set_in(8, 1'b0, 0, 0, 1'b0);
    set_in(16, 1'b0, 0, 0, 1'b0);
    or8 = 1'b0; or16 = 1'b0;
    #12;
    check("rst_in_ready8", {63'd0, rdy8}, 64'd1);
    check("rst_out_valid8", {63'd0, ov8}, 64'd0);
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    check("rst_result8", get_res(8), 64'd0);
    check("rst_in_ready16", {63'd0, rdy16}, 64'd1);
    check("rst_result16", get_res(16), 64'd0);
    rst_n = 1'b1;

    // First edge after release accepts.
    start_op(8, 32'h89, 32'h26, 1'b1);
    check("accept_first_edge_busy", {63'd0, busy8}, 64'd1);
    wait_done(8, res, lat);
    check("signed_89x26", res, 64'hEE56);
    check("latency_w8", 64'(lat), 64'd6);
    ack(8);
    check("idle_after_ack", {63'd0, ov8}, 64'd0);

    start_op(8, 32'h89, 32'h26, 1'b0);
    wait_done(8, res, lat);
    check("unsigned_89x26", res, 64'h1456);
    ack(8);
    start_op(8, 32'h80, 32'h80, 1'b1);
    wait_done(8, res, lat);
    check("signed_80x80", res, 64'h4000);
    ack(8);
    start_op(8, 32'hFF, 32'hFF, 1'b0);
    wait_done(8, res, lat);
    check("unsigned_FFxFF", res, 64'hFE01);
    ack(8);

    // Back-pressure, then handoff with a simultaneous accept.
    start_op(8, 32'h89, 32'h26, 1'b1);
    wait_done(8, res, lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_result_stable", get_res(8), 64'hEE56);
      check("bp_in_ready_low", {63'd0, rdy8}, 64'd0);
      check("bp_out_valid_held", {63'd0, ov8}, 64'd1);
    end
    set_or(8, 1'b1);
    set_in(8, 1'b1, 32'h7F, 32'h7F, 1'b1);
    #1;
    check("handoff_in_ready", {63'd0, rdy8}, 64'd1);
    tick();
    set_or(8, 1'b0);
    set_in(8, 1'b0, 0, 0, 1'b0);
    check("handoff_out_valid_drop", {63'd0, ov8}, 64'd0);
    check("handoff_busy", {63'd0, busy8}, 64'd1);
    wait_done(8, res, lat);
    check("handoff_product", res, 64'h3F01);
    check("handoff_latency", 64'(lat), 64'd6);
    ack(8);

    // Input churn during CALC must not disturb the product.
    start_op(8, 32'h89, 32'h26, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_in(8, i[0], $urandom, $urandom, i[1]);
      tick();
      check("churn_busy", {63'd0, busy8}, 64'd1);
    end
    set_in(8, 1'b0, $urandom, $urandom, 1'b0);
    wait_done(8, res, lat);
    check("churn_product", res, 64'hEE56);
    ack(8);

    // Reset in the middle of iterating.
    start_op(8, 32'h55, 32'h33, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, ov8}, 64'd0);
    check("midrst_busy", {63'd0, busy8}, 64'd0);
    check("midrst_in_ready", {63'd0, rdy8}, 64'd1);
    check("midrst_result", get_res(8), 64'd0);
    tick();
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ov8 || busy8) stray = 1'b1;
    end
    check("midrst_no_stray", {63'd0, stray}, 64'd0);

    // W=16 corners.
    start_op(16, 32'h8000, 32'h8000, 1'b1);
    wait_done(16, res, lat);
    check("w16_signed_min_sq", res, 64'h40000000);
    check("latency_w16", 64'(lat), 64'd10);
    ack(16);
    start_op(16, 32'hFFFF, 32'hFFFF, 1'b0);
    wait_done(16, res, lat);
    check("w16_unsigned_max_sq", res, 64'hFFFE0001);
    ack(16);

    // Random pairs per width and mode.
    for (int wi = 0; wi < 2; wi++) begin
      for (int sm = 0; sm < 2; sm++) begin
        for (int k = 0; k < 1000; k++) begin
          int w;
          w  = (wi == 0) ? 8 : 16;
          ra = $urandom;
          rb = $urandom;
          start_op(w, ra, rb, sm[0]);
          wait_done(w, res, lat);
          check("random_product", res, ref_mul(w, ra, rb, sm[0]));
          ack(w);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth2_mult_param.md
BOOTH2_MULT_PARAM -- requirements
Module: booth2_mult_param

Interface
REQ-001 SHALL have parameter W, default 8, operand width; even, 4..32.
REQ-002 SHALL have port CLK  input  1  sole clock, rising-edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operands and mode present.
REQ-005 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-006 SHALL have port x  input  W  multiplicand.
REQ-007 SHALL have port multiplier  input  W  multiplier, recoded radix-4 Booth.
REQ-008 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port out_valid  output  1  result is valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  2W  product.
REQ-012 SHALL have port busy  output  1  high in CALC.

Function
REQ-013 SHALL be an iterative radix-4 Booth multiplier: one partial product added per CALC cycle.
REQ-014 SHALL extend both operands to W+2 bits: sign-extend if is_signed=1, zero-extend otherwise.
REQ-015 SHALL iterate N = W/2+1 Booth digits for both modes (fixed latency), giving 5 for W=8.
REQ-016 SHALL recode digits from the triplet (m[2i+1], m[2i], m[2i-1]), with m[-1]=0, into {0, +1, +2, -1, -2}; -x and -2x formed by invert-plus-one in the adder.
REQ-017 SHALL keep the accumulator at 2W+4 bits internally; result = low 2W bits, which is exact for all operand pairs.
REQ-018 SHALL have FSM states IDLE, CALC, DONE: IDLE->CALC on accept; CALC->DONE after N iterations; DONE->IDLE on out_ready with no new accept; DONE->CALC on out_ready with a simultaneous accept.
REQ-019 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready); accept = in_valid and in_ready.
REQ-020 SHALL capture x, multiplier and is_signed on the accept edge; later input changes SHALL NOT affect the operation in flight.
REQ-021 SHALL assert out_valid exactly N+1 rising edges after the accept edge and hold it until out_ready is sampled high.
REQ-022 SHALL hold result stable while out_valid is high and out_ready is low.
REQ-023 SHALL ignore in_valid while in CALC.
REQ-024 SHALL, on back-to-back operation, drop out_valid on the handoff edge and start the new operation with no idle cycle.

Reset
REQ-025 SHALL, while RST=0, force state=IDLE, in_ready=1, out_valid=0, busy=0, result=0 and clear the accumulator, independent of CLK.
REQ-026 SHALL, if reset is asserted mid-CALC or in DONE, discard the operation; no out_valid follows after reset release.
REQ-027 SHALL be able to accept on the first rising edge after RST deasserts.

Structure
REQ-028 SHALL place the FSM state enum, the Booth digit encoding constants and the N-from-W function in shared package booth2_pkg.
REQ-029 SHALL implement the digit recoder and partial-product selector (0/±x/±2x, W+3 bits) as sub-module booth2_pp_gen, instantiated once.
REQ-030 SHALL use a single adder plus a 2-bit-per-cycle arithmetic shift of the accumulator/multiplier register, with no W-wide array.

Verification
REQ-031 SHALL cover, with W=8, signed: x=0x89, multiplier=0x26 -> result=0xEE56 (-4522); out_valid 6 edges after accept.
REQ-032 SHALL cover, with W=8, unsigned: x=0x89, multiplier=0x26 -> result=0x1456; signed x=0x80, multiplier=0x80 -> 0x4000; unsigned x=0xFF, multiplier=0xFF -> 0xFE01.
REQ-033 SHALL cover back-pressure: out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0; then out_ready=1 together with in_valid -> new operation accepted on the same edge.
REQ-034 SHALL cover reset mid-operation: RST=0 at iteration 2 -> outputs at reset values immediately; after release, no stray out_valid.
REQ-035 SHALL cover operand changes and in_valid toggling during CALC -> no effect on the product; 1000 random pairs per mode against a reference model, for W=8 and W=16.
